axis_demux: RTL and testbench
=============================

Name: axis_demux

Overview:
- Packet-atomic 1-to-2 AXI-Stream router; the inverse of the two-slave stream arbiter.
- Accepts one slave stream (s0k) and steers each whole packet to master port m0a or m0b, chosen by tdest on the first beat.
- One registered output stage per master; full throughput when the selected master is ready.
- Sits downstream of the arbiter so that merged traffic can be split back out by source tag.

Parameters:
- DATA_WIDTH, 32, width of tdata on all ports.
- CNT_WIDTH, 16, width of the per-port packet counters and the drop counter.

Ports:
- axis_aclk  in  1  clock; all logic on the rising edge.
- axis_aresetn  in  1  synchronous, active-low reset.
- s0k_axis_tdata  in  DATA_WIDTH  input data.
- s0k_axis_tvalid  in  1  input valid.
- s0k_axis_tready  out  1  input ready.
- s0k_axis_tlast  in  1  last beat of packet.
- s0k_axis_tdest  in  2  destination: 0 = m0a, 1 = m0b, 2/3 = invalid.
- m0a_axis_tdata  out  DATA_WIDTH  port A data.
- m0a_axis_tvalid  out  1  port A valid.
- m0a_axis_tready  in  1  port A ready.
- m0a_axis_tlast  out  1  port A last.
- m0b_axis_tdata / tvalid / tready / tlast  as for m0a, port B.
- pkt_cnt_a  out  CNT_WIDTH  packets completed on m0a (tlast handshakes).
- pkt_cnt_b  out  CNT_WIDTH  packets completed on m0b.
- drop_cnt  out  CNT_WIDTH  packets dropped.

Behaviour:
- Reset: all m*_tvalid=0, m*_tlast=0, m*_tdata=0, counters=0, FSM=IDLE; s0k_axis_tready=0 while axis_aresetn=0.
- FSM states:
  - IDLE: no packet open; tdest is sampled on the current beat.
  - FWD_A / FWD_B: packet open; tdest is ignored.
  - DROP: exists only with the macro.
- Transitions:
  - IDLE, on a handshake without tlast: FWD_A if tdest=0, FWD_B if tdest=1, DROP if tdest is invalid (macro on).
  - FWD_x, on a tlast handshake: IDLE.
  - A single-beat packet (tlast on the first beat) routes the beat and stays in IDLE.
- Output stage per port:
  - Holding register plus valid bit.
  - Ready condition: rdy_x = ~m0x_tvalid | m0x_tready.
  - Latency: accepted beat appears on m0x one cycle after the s0k handshake.
- s0k_axis_tready:
  - rdy of the selected port; in IDLE the port is selected combinationally from s0k_axis_tdest.
  - The non-selected port never back-pressures the input.
  - tready must not depend on s0k_axis_tvalid.
- Register update: same-cycle drain and refill of a port register is allowed (back-to-back beats, no bubble).
- tdest changes mid-packet are ignored: a packet is never split across ports.
- Counters:
  - pkt_cnt_x increments on each m0x tvalid&tready&tlast.
  - Wraps modulo 2^CNT_WIDTH.
- Simultaneous events: a port-A drain and a port-B drain in the same cycle are independent; both counters may increment.
- Reset mid-packet: the partial packet is lost, output registers are cleared, and the first beat after reset is treated as packet start.
- No data reordering within a port; packets leave each port in arrival order.

Optional Feature:
- Macro: AXIS_DEMUX_DROP_EN.
- Defined:
  - Invalid tdest (2/3) on the first beat enters DROP.
  - s0k_axis_tready=1 in DROP, and beats are discarded up to and including tlast.
  - drop_cnt increments once per packet, on the tlast handshake (including single-beat invalid packets).
- Undefined:
  - Invalid tdest is routed to m0a as if tdest=0.
  - DROP state is absent; drop_cnt is tied to 0.

Test Plan:
- Reset, then 31-beat packet on tdest=0 with data 1..31, m0a_tready=1 -> m0a carries 1..31 with tlast on 31, one-cycle latency, m0b_tvalid never 1, pkt_cnt_a=1.
- Alternating single-beat packets: tdest 0,1,0,1 with data 0xA0..0xA3, both readies=1 -> 0xA0/0xA2 on m0a, 0xA1/0xA3 on m0b, no bubbles, pkt_cnt_a=pkt_cnt_b=2.
- Packet to B with tdest toggled to 0 on beats 2..4 of 5 -> all 5 beats on m0b only.
- Pseudorandom m0a_tready (LFSR) on a 31-beat packet to A while m0b_tready=0 -> no data lost, duplicated or reordered; s0k_tready tracks port A only.
- axis_aresetn low for 2 cycles after beat 10 of a 31-beat packet to A -> outputs and counters clear; next packet with tdest=1 goes to m0b.
- tdest=3 on a 4-beat packet -> with AXIS_DEMUX_DROP_EN: no output beats, tready=1 throughout, drop_cnt=1; without the macro: 4 beats on m0a, drop_cnt=0.

Source files
------------

// File: rtl/axis_demux.sv
// axis_demux: packet-atomic 1-to-2 AXI-Stream router.
// The first beat of each packet picks the output port from tdest
// (0 -> m0a, 1 -> m0b). Every beat of the packet then goes to that port
// until its tlast beat has been accepted. Each master has one registered
// output stage, so the router keeps full throughput while that master is ready.
// Optional build macro AXIS_DEMUX_DROP_EN: packets whose first-beat tdest
// is 2 or 3 are swallowed and counted in drop_cnt. Without the macro they
// are sent to m0a and drop_cnt stays at zero.
module axis_demux #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  axis_aclk,
  input  logic                  axis_aresetn,
  input  logic [DATA_WIDTH-1:0] s0k_axis_tdata,
  input  logic                  s0k_axis_tvalid,
  output logic                  s0k_axis_tready,
  input  logic                  s0k_axis_tlast,
  input  logic [1:0]            s0k_axis_tdest,
  output logic [DATA_WIDTH-1:0] m0a_axis_tdata,
  output logic                  m0a_axis_tvalid,
  input  logic                  m0a_axis_tready,
  output logic                  m0a_axis_tlast,
  output logic [DATA_WIDTH-1:0] m0b_axis_tdata,
  output logic                  m0b_axis_tvalid,
  input  logic                  m0b_axis_tready,
  output logic                  m0b_axis_tlast,
  output logic [CNT_WIDTH-1:0]  pkt_cnt_a,
  output logic [CNT_WIDTH-1:0]  pkt_cnt_b,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

`ifdef AXIS_DEMUX_DROP_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FWD_A = 2'd1,
    ST_FWD_B = 2'd2,
    ST_DROP  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FWD_A = 2'd1,
    ST_FWD_B = 2'd2
  } state_t;
`endif

  state_t                r_state;
  state_t                w_state_nxt;

  logic [DATA_WIDTH-1:0] r_a_data;
  logic                  r_a_valid;
  logic                  r_a_last;
  logic [DATA_WIDTH-1:0] r_b_data;
  logic                  r_b_valid;
  logic                  r_b_last;
  logic [CNT_WIDTH-1:0]  r_pkt_cnt_a;
  logic [CNT_WIDTH-1:0]  r_pkt_cnt_b;

  logic                  w_sel_a;
  logic                  w_sel_b;
  logic                  w_sel_drop;
  logic                  w_rdy_a;
  logic                  w_rdy_b;
  logic                  w_tready;
  logic                  w_hs;
  logic                  w_drain_a;
  logic                  w_drain_b;

  // An output register can take a new beat when it is empty or draining this cycle.
  assign w_rdy_a   = ~r_a_valid | m0a_axis_tready;
  assign w_rdy_b   = ~r_b_valid | m0b_axis_tready;
  assign w_drain_a = r_a_valid & m0a_axis_tready;
  assign w_drain_b = r_b_valid & m0b_axis_tready;

  // Port selection: taken from tdest when no packet is open, otherwise from the open packet.
  always_comb begin
    w_sel_a    = 1'b0;
    w_sel_b    = 1'b0;
    w_sel_drop = 1'b0;
    case (r_state)
      ST_IDLE: begin
        case (s0k_axis_tdest)
          2'd0: w_sel_a = 1'b1;
          2'd1: w_sel_b = 1'b1;
          default: begin
`ifdef AXIS_DEMUX_DROP_EN
            w_sel_drop = 1'b1;
`else
            w_sel_a    = 1'b1;
`endif
          end
        endcase
      end
      ST_FWD_A: w_sel_a = 1'b1;
      ST_FWD_B: w_sel_b = 1'b1;
`ifdef AXIS_DEMUX_DROP_EN
      ST_DROP:  w_sel_drop = 1'b1;
`endif
      default: begin
        w_sel_a    = 1'b0;
        w_sel_b    = 1'b0;
        w_sel_drop = 1'b0;
      end
    endcase
  end

  // Only the selected port can back-pressure the input. tready is
  // independent of tvalid and is held low while reset is asserted.
  assign w_tready = axis_aresetn &
                    ((w_sel_a & w_rdy_a) | (w_sel_b & w_rdy_b) | w_sel_drop);
  assign w_hs     = s0k_axis_tvalid & w_tready;
  assign s0k_axis_tready = w_tready;

  // Next-state logic: a packet opens on a non-last first beat and closes on its tlast beat.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_hs && !s0k_axis_tlast) begin
          if (w_sel_b) begin
            w_state_nxt = ST_FWD_B;
          end else if (w_sel_a) begin
            w_state_nxt = ST_FWD_A;
          end else begin
`ifdef AXIS_DEMUX_DROP_EN
            w_state_nxt = ST_DROP;
`else
            w_state_nxt = ST_IDLE;
`endif
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FWD_A, ST_FWD_B: begin
        if (w_hs && s0k_axis_tlast) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
`ifdef AXIS_DEMUX_DROP_EN
      ST_DROP: begin
        if (w_hs && s0k_axis_tlast) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DROP;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Port A holding register: a refill takes priority, so draining and refilling can happen in the same cycle.
  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      r_a_data  <= '0;
      r_a_valid <= 1'b0;
      r_a_last  <= 1'b0;
    end else if (w_hs && w_sel_a) begin
      r_a_data  <= s0k_axis_tdata;
      r_a_valid <= 1'b1;
      r_a_last  <= s0k_axis_tlast;
    end else if (w_drain_a) begin
      r_a_valid <= 1'b0;
      r_a_last  <= 1'b0;
    end
  end

  // Port B holding register: same drain and refill behaviour as port A.
  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      r_b_data  <= '0;
      r_b_valid <= 1'b0;
      r_b_last  <= 1'b0;
    end else if (w_hs && w_sel_b) begin
      r_b_data  <= s0k_axis_tdata;
      r_b_valid <= 1'b1;
      r_b_last  <= s0k_axis_tlast;
    end else if (w_drain_b) begin
      r_b_valid <= 1'b0;
      r_b_last  <= 1'b0;
    end
  end

  // Packet counters count completed output packets (tlast handshakes) and wrap around.
  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      r_pkt_cnt_a <= '0;
      r_pkt_cnt_b <= '0;
    end else begin
      if (w_drain_a && r_a_last) begin
        r_pkt_cnt_a <= r_pkt_cnt_a + CNT_ONE;
      end
      if (w_drain_b && r_b_last) begin
        r_pkt_cnt_b <= r_pkt_cnt_b + CNT_ONE;
      end
    end
  end

`ifdef AXIS_DEMUX_DROP_EN
  logic [CNT_WIDTH-1:0] r_drop_cnt;

  // Drop counter advances once per discarded packet, on its tlast handshake.
  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      r_drop_cnt <= '0;
    end else if (w_hs && w_sel_drop && s0k_axis_tlast) begin
      r_drop_cnt <= r_drop_cnt + CNT_ONE;
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = '0;
`endif

  assign m0a_axis_tdata  = r_a_data;
  assign m0a_axis_tvalid = r_a_valid;
  assign m0a_axis_tlast  = r_a_last;
  assign m0b_axis_tdata  = r_b_data;
  assign m0b_axis_tvalid = r_b_valid;
  assign m0b_axis_tlast  = r_b_last;
  assign pkt_cnt_a       = r_pkt_cnt_a;
  assign pkt_cnt_b       = r_pkt_cnt_b;

endmodule

// File: tb/tb_axis_demux.sv
// Self-checking bench for axis_demux. Each beat the DUT accepts is routed by
// packet rules into a per-port queue of pending output beats. Because each
// port has one output register, that queue holds at most one entry. Its head
// is the beat the port must show one cycle after the input handshake. The
// expected counters advance when a tlast beat leaves a port.
module tb_axis_demux;

`ifdef AXIS_DEMUX_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic        clk;
  logic        rstn;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [1:0]  s_tdest;
  logic [31:0] a_tdata;
  logic        a_tvalid;
  logic        a_tready;
  logic        a_tlast;
  logic [31:0] b_tdata;
  logic        b_tvalid;
  logic        b_tready;
  logic        b_tlast;
  logic [15:0] cnt_a;
  logic [15:0] cnt_b;
  logic [15:0] cnt_d;

  axis_demux #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .axis_aclk       (clk),
    .axis_aresetn    (rstn),
    .s0k_axis_tdata  (s_tdata),
    .s0k_axis_tvalid (s_tvalid),
    .s0k_axis_tready (s_tready),
    .s0k_axis_tlast  (s_tlast),
    .s0k_axis_tdest  (s_tdest),
    .m0a_axis_tdata  (a_tdata),
    .m0a_axis_tvalid (a_tvalid),
    .m0a_axis_tready (a_tready),
    .m0a_axis_tlast  (a_tlast),
    .m0b_axis_tdata  (b_tdata),
    .m0b_axis_tvalid (b_tvalid),
    .m0b_axis_tready (b_tready),
    .m0b_axis_tlast  (b_tlast),
    .pkt_cnt_a       (cnt_a),
    .pkt_cnt_b       (cnt_b),
    .drop_cnt        (cnt_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        l;
    logic [31:0] d;
  } beat_t;

  typedef struct {
    logic        v;
    logic [1:0]  td;
    logic [31:0] d;
    logic        er;
    logic        av;
    logic [31:0] ad;
    logic        bv;
    logic [31:0] bd;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  beat_t       qa[$];
  beat_t       qb[$];
  bit          pkt_open = 1'b0;
  int          pkt_dest = 0;
  logic [15:0] ecnt_a = 16'd0;
  logic [15:0] ecnt_b = 16'd0;
  logic [15:0] ecnt_d = 16'd0;
  bit          last_hs = 1'b0;
  bit          rst_seen = 1'b0;
  int          mode_a = 0;
  int          mode_b = 0;
  logic [7:0]  lfsr = 8'hA5;
  vec_t        tbl[6];
  bit          tbl_en = 1'b0;
  int          tbl_idx = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int route(input logic [1:0] td);
    if (td == 2'd1) return 1;
    if (td == 2'd0) return 0;
    return DROP_EN ? 2 : 0;
  endfunction

  // One clock cycle. Compare the DUT with the model at the falling edge,
  // advance the model, then pass the rising edge.
  task automatic step();
    int  sel;
    bit  erdy;
    beat_t bt;
    @(negedge clk);
    if (!rstn) begin
      chk("tready_in_reset", s_tready, 1'b0);
      if (rst_seen) begin
        chk("rst_a_valid", a_tvalid, 1'b0);
        chk("rst_b_valid", b_tvalid, 1'b0);
        chk("rst_a_last", a_tlast, 1'b0);
        chk("rst_a_data", a_tdata, 32'd0);
        chk("rst_cnt_a", cnt_a, 16'd0);
        chk("rst_cnt_b", cnt_b, 16'd0);
        chk("rst_cnt_d", cnt_d, 16'd0);
      end
      rst_seen = 1'b1;
      qa.delete();
      qb.delete();
      pkt_open = 1'b0;
      ecnt_a = 16'd0;
      ecnt_b = 16'd0;
      ecnt_d = 16'd0;
      last_hs = 1'b0;
    end else begin
      rst_seen = 1'b0;
      chk("a_valid", a_tvalid, qa.size() != 0);
      if (qa.size() != 0) begin
        chk("a_data", a_tdata, qa[0].d);
        chk("a_last", a_tlast, qa[0].l);
      end
      chk("b_valid", b_tvalid, qb.size() != 0);
      if (qb.size() != 0) begin
        chk("b_data", b_tdata, qb[0].d);
        chk("b_last", b_tlast, qb[0].l);
      end
      sel = pkt_open ? pkt_dest : route(s_tdest);
      if (sel == 0) erdy = (qa.size() == 0) || a_tready;
      else if (sel == 1) erdy = (qb.size() == 0) || b_tready;
      else erdy = 1'b1;
      chk("s_tready", s_tready, erdy);
      chk("pkt_cnt_a", cnt_a, ecnt_a);
      chk("pkt_cnt_b", cnt_b, ecnt_b);
      chk("drop_cnt", cnt_d, ecnt_d);
      if (tbl_en) begin
        chk("tbl_tready", s_tready, tbl[tbl_idx].er);
        chk("tbl_a_valid", a_tvalid, tbl[tbl_idx].av);
        if (tbl[tbl_idx].av) chk("tbl_a_data", a_tdata, tbl[tbl_idx].ad);
        chk("tbl_b_valid", b_tvalid, tbl[tbl_idx].bv);
        if (tbl[tbl_idx].bv) chk("tbl_b_data", b_tdata, tbl[tbl_idx].bd);
      end
      // Model update for the coming rising edge.
      if (qa.size() != 0 && a_tready) begin
        bt = qa.pop_front();
        if (bt.l) ecnt_a++;
      end
      if (qb.size() != 0 && b_tready) begin
        bt = qb.pop_front();
        if (bt.l) ecnt_b++;
      end
      last_hs = s_tvalid && erdy;
      if (last_hs) begin
        bt.d = s_tdata;
        bt.l = s_tlast;
        if (sel == 0) qa.push_back(bt);
        else if (sel == 1) qb.push_back(bt);
        if (s_tlast) begin
          pkt_open = 1'b0;
          if (sel == 2) ecnt_d++;
        end else if (!pkt_open) begin
          pkt_open = 1'b1;
          pkt_dest = sel;
        end
      end
    end
    @(posedge clk);
    #1;
    lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    if (mode_a == 1) a_tready = lfsr[0];
    else if (mode_a == 2) a_tready = 1'($urandom_range(0, 1));
    if (mode_b == 2) b_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int n);
    s_tvalid = 1'b0;
    rstn = 1'b0;
    for (int i = 0; i < n; i++) step();
    rstn = 1'b1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [1:0] td, input logic l);
    int waited;
    s_tdata  = d;
    s_tdest  = td;
    s_tlast  = l;
    s_tvalid = 1'b1;
    waited   = 0;
    do begin
      step();
      waited++;
    end while (!last_hs && waited < 300);
    if (!last_hs) chk("beat_accept_timeout", 1'b0, 1'b1);
  endtask

  // Send a packet. When toggle is set, beats 2..4 carry tdest 0 to confirm that tdest is ignored mid-packet.
  task automatic send_pkt(input logic [1:0] td, input int len, input logic [31:0] base,
                          input bit toggle, input int gap_max);
    int ng;
    for (int i = 0; i < len; i++) begin
      ng = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      if (ng > 0) idle(ng);
      send_beat(base + 32'(i), (toggle && i >= 1 && i <= 3) ? 2'd0 : td, i == len - 1);
    end
    s_tvalid = 1'b0;
  endtask

  initial begin
    logic [15:0] cb0;
    logic [15:0] ca0;
    // Alternating single-beat packets. The outputs listed in each row are the result of the previous row's input.
    tbl[0] = '{v: 1'b1, td: 2'd0, d: 32'hA0, er: 1'b1, av: 1'b0, ad: 32'h0,  bv: 1'b0, bd: 32'h0};
    tbl[1] = '{v: 1'b1, td: 2'd1, d: 32'hA1, er: 1'b1, av: 1'b1, ad: 32'hA0, bv: 1'b0, bd: 32'h0};
    tbl[2] = '{v: 1'b1, td: 2'd0, d: 32'hA2, er: 1'b1, av: 1'b0, ad: 32'h0,  bv: 1'b1, bd: 32'hA1};
    tbl[3] = '{v: 1'b1, td: 2'd1, d: 32'hA3, er: 1'b1, av: 1'b1, ad: 32'hA2, bv: 1'b0, bd: 32'h0};
    tbl[4] = '{v: 1'b0, td: 2'd0, d: 32'h0,  er: 1'b1, av: 1'b0, ad: 32'h0,  bv: 1'b1, bd: 32'hA3};
    tbl[5] = '{v: 1'b0, td: 2'd0, d: 32'h0,  er: 1'b1, av: 1'b0, ad: 32'h0,  bv: 1'b0, bd: 32'h0};

    rstn = 1'b0;
    s_tvalid = 1'b0;
    s_tdata = 32'd0;
    s_tlast = 1'b0;
    s_tdest = 2'd0;
    a_tready = 1'b1;
    b_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset(2);

    // 31-beat packet to A with data 1..31.
    send_pkt(2'd0, 31, 32'd1, 1'b0, 0);
    idle(3);
    chk("t1_pkt_cnt_a", cnt_a, 16'd1);
    chk("t1_pkt_cnt_b", cnt_b, 16'd0);

    // Alternating single-beat packets from the table.
    do_reset(2);
    for (int i = 0; i < 6; i++) begin
      s_tvalid = tbl[i].v;
      s_tdest  = tbl[i].td;
      s_tdata  = tbl[i].d;
      s_tlast  = 1'b1;
      tbl_idx  = i;
      tbl_en   = 1'b1;
      step();
    end
    tbl_en = 1'b0;
    chk("t2_pkt_cnt_a", cnt_a, 16'd2);
    chk("t2_pkt_cnt_b", cnt_b, 16'd2);

    // Packet to B whose tdest toggles to 0 mid-packet.
    ca0 = cnt_a;
    cb0 = cnt_b;
    send_pkt(2'd1, 5, 32'h100, 1'b1, 0);
    idle(3);
    chk("t3_pkt_cnt_b", cnt_b, cb0 + 16'd1);
    chk("t3_pkt_cnt_a", cnt_a, ca0);

    // Pseudorandom ready on A while B is stalled.
    b_tready = 1'b0;
    mode_a = 1;
    send_pkt(2'd0, 31, 32'h200, 1'b0, 0);
    mode_a = 0;
    a_tready = 1'b1;
    idle(3);
    b_tready = 1'b1;
    idle(2);

    // Reset in the middle of a packet.
    for (int i = 0; i < 10; i++) send_beat(32'h300 + 32'(i), 2'd0, 1'b0);
    do_reset(2);
    chk("t5_a_valid", a_tvalid, 1'b0);
    chk("t5_cnt_a", cnt_a, 16'd0);
    send_pkt(2'd1, 3, 32'h380, 1'b0, 0);
    idle(3);
    chk("t5_pkt_cnt_b", cnt_b, 16'd1);
    chk("t5_pkt_cnt_a", cnt_a, 16'd0);

    // Invalid tdest: the packet is dropped or routed to A, depending on the build.
    do_reset(2);
    send_pkt(2'd3, 4, 32'h400, 1'b0, 0);
    idle(3);
    chk("t6_drop_cnt", cnt_d, DROP_EN ? 16'd1 : 16'd0);
    chk("t6_pkt_cnt_a", cnt_a, DROP_EN ? 16'd0 : 16'd1);

    // Random traffic with random readies and idle gaps.
    mode_a = 2;
    mode_b = 2;
    for (int p = 0; p < 150; p++) begin
      send_pkt(2'($urandom_range(0, 3)), $urandom_range(1, 6), $urandom, 1'b0, 2);
    end
    mode_a = 0;
    mode_b = 0;
    a_tready = 1'b1;
    b_tready = 1'b1;
    idle(4);
    chk("final_qa_empty", qa.size(), 0);
    chk("final_qb_empty", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
